// File: rtl/fsm_bit_serializer.sv
// fsm_bit_serializer
//   Parallel-to-serial front end for the sequence-detector FSMs. Whole words
//   arrive over a valid/ready load interface and leave one bit per clock on x.
//   A one-word holding buffer lets consecutive words stream with no idle cycle.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-high; clears all state
//   data_in    in   [WIDTH] word to serialize, sampled on an accepting edge
//   load_valid in   data_in is valid
//   load_ready out  block can accept a word (holding buffer empty)
//   x          out  serial bit, registered; IDLE_BIT when x_valid is 0
//   x_valid    out  x carries a data bit this cycle, registered
//   last_bit   out  x is the final bit of the current word
//   busy       out  shifter active or holding buffer full
module fsm_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             accept;
    logic             at_last;

    // Move the shift register one position toward the output end.
    function automatic logic [WIDTH-1:0] shift_sr(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return {v[WIDTH-2:0], IDLE_BIT};
        end else begin
            return {IDLE_BIT, v[WIDTH-1:1]};
        end
    endfunction

    // Bit of the shift register that sits at the output end.
    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return v[WIDTH-1];
        end else begin
            return v[0];
        end
    endfunction

    assign load_ready = !hold_full_q;
    assign accept     = load_valid && !hold_full_q;
    assign at_last    = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d    = data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!at_last) begin
                    sr_d  = shift_sr(sr_q);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (accept) begin
                        hold_d      = data_in;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // load_ready is low here, so no accept can collide with the drain.
                    sr_d        = hold_q;
                    cnt_d       = '0;
                    hold_full_d = 1'b0;
                end else if (accept) begin
                    // Gapless hand-off: the new word bypasses the holding buffer.
                    sr_d  = data_in;
                    cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // x is registered, so it is computed from the state about to be entered.
        x_valid_d = (state_d == SHIFT);
        x_d       = (state_d == SHIFT) ? out_bit(sr_d) : IDLE_BIT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            x_q         <= IDLE_BIT;
            x_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            x_q         <= x_d;
            x_valid_q   <= x_valid_d;
        end
    end

    assign x        = x_q;
    assign x_valid  = x_valid_q;
    assign last_bit = (state_q == SHIFT) && at_last;
    assign busy     = (state_q == SHIFT) || hold_full_q;

endmodule

// File: tb/tb_fsm_bit_serializer.sv
// Testbench for fsm_bit_serializer: two instances (MSB-first and LSB-first,
// both 8-bit). Accepted words are expanded into their expected bit streams
// and queued; a negedge monitor pops and compares whenever bits are pending.
module tb_fsm_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] din0 = '0, din1 = '0;
    logic         lv0 = 1'b0, lv1 = 1'b0;
    logic         rdy0, x0, xv0, lb0, bz0;
    logic         rdy1, x1, xv1, lb1, bz1;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    // Each entry: {last, bit}
    bit [1:0] exp0[$];
    bit [1:0] exp1[$];

    always #5 clk = ~clk;

    fsm_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .data_in(din0), .load_valid(lv0),
        .load_ready(rdy0), .x(x0), .x_valid(xv0), .last_bit(lb0), .busy(bz0)
    );

    fsm_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut1 (
        .clk(clk), .reset(reset), .data_in(din1), .load_valid(lv1),
        .load_ready(rdy1), .x(x1), .x_valid(xv1), .last_bit(lb1), .busy(bz1)
    );

    task automatic chk(input string name, input int k, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[inst%0d] actual=%0b expected=%0b at %0t", name, k, act, exp, $time);
        end
    endtask

    // Reference: a word becomes WIDTH bits in transmission order.
    task automatic push_word(input int k, input logic [W-1:0] d);
        for (int i = 0; i < W; i++) begin
            bit b;
            bit [1:0] e;
            b = (k == 0) ? d[W-1-i] : d[i];
            e = {(i == W - 1), b};
            if (k == 0) exp0.push_back(e);
            else        exp1.push_back(e);
        end
    endtask

    // Pending bit count R decides everything observable: busy = R>0,
    // x_valid = R>0 (stream is gapless), load_ready = R<=W (holding buffer free).
    task automatic mon(input int k, input logic xx, input logic xv, input logic lb,
                       input logic bz, input logic rdy);
        int n;
        bit [1:0] e;
        n = (k == 0) ? exp0.size() : exp1.size();
        chk("busy", k, bz, n > 0);
        chk("load_ready", k, rdy, n <= W);
        chk("x_valid", k, xv, n > 0);
        if (n > 0) begin
            e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
            chk("x", k, xx, e[0]);
            chk("last_bit", k, lb, e[1]);
        end else begin
            chk("x_idle", k, xx, 1'b0);
            chk("last_bit_idle", k, lb, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            mon(0, x0, xv0, lb0, bz0, rdy0);
            mon(1, x1, xv1, lb1, bz1, rdy1);
        end
    end

    // Drive one cycle of stimulus on instance k; the other instance is idle.
    task automatic step(input int k, input bit v, input logic [W-1:0] d, output bit acc);
        @(negedge clk);
        lv0  = (k == 0) && v;
        lv1  = (k == 1) && v;
        din0 = (k == 0) ? d : $urandom;
        din1 = (k == 1) ? d : $urandom;
        #1;
        acc = (k == 0) ? (lv0 && rdy0 && !reset) : (lv1 && rdy1 && !reset);
        if (acc) push_word(k, d);
    endtask

    task automatic idle_cycle();
        bit a;
        step(0, 1'b0, '0, a);
    endtask

    task automatic drain();
        int budget;
        budget = 100;
        while ((exp0.size() != 0 || exp1.size() != 0) && budget > 0) begin
            idle_cycle();
            budget--;
        end
        checks++;
        if (budget == 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d/%0d expected=0/0", exp0.size(), exp1.size());
        end
        idle_cycle();
        idle_cycle();
    endtask

    // Offer a list of words on instance k with load_valid held high.
    task automatic stream(input int k, input logic [W-1:0] words[$]);
        int idx;
        int budget;
        bit a;
        idx = 0;
        budget = 200;
        while (idx < words.size() && budget > 0) begin
            step(k, 1'b1, words[idx], a);
            if (a) idx++;
            budget--;
        end
        checks++;
        if (budget == 0) begin
            failures++;
            $display("FAIL stream_timeout actual=%0d expected=%0d", idx, words.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_x"}, 0, x0, 1'b0);
        chk({tag, "_x_valid"}, 0, xv0, 1'b0);
        chk({tag, "_last_bit"}, 0, lb0, 1'b0);
        chk({tag, "_busy"}, 0, bz0, 1'b0);
        chk({tag, "_load_ready"}, 0, rdy0, 1'b1);
        chk({tag, "_x_valid"}, 1, xv1, 1'b0);
        chk({tag, "_busy"}, 1, bz1, 1'b0);
        chk({tag, "_load_ready"}, 1, rdy1, 1'b1);
    endtask

    initial begin
        logic [W-1:0] wl[$];
        bit a;

        // Reset for 2 cycles with load_valid high: nothing may load.
        reset = 1'b1;
        lv0 = 1'b1; lv1 = 1'b1; din0 = 8'hA5; din1 = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        lv0 = 1'b0; lv1 = 1'b0;
        reset = 1'b0;
        mon_en = 1'b1;
        idle_cycle();
        idle_cycle();

        // Single word, MSB first.
        step(0, 1'b1, 8'hB4, a);
        chk("accept_b4", 0, a, 1'b1);
        drain();

        // Back-to-back stream with backpressure on the third word.
        wl = '{8'h0F, 8'hF0, 8'hAA};
        stream(0, wl);
        drain();

        // LSB first.
        step(1, 1'b1, 8'h06, a);
        chk("accept_06", 1, a, 1'b1);
        drain();

        // Reset at bit 3 of 8'hFF with a word waiting in hold.
        step(0, 1'b1, 8'hFF, a);
        step(0, 1'b1, 8'h55, a);
        chk("hold_capture", 0, a, 1'b1);
        step(0, 1'b0, '0, a);
        step(0, 1'b0, '0, a);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        exp0.delete();
        exp1.delete();
        check_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(0, 1'b1, 8'h81, a);
        chk("accept_81", 0, a, 1'b1);
        drain();

        // Randomized traffic on each instance.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 400; i++) begin
                step(k, ($urandom_range(0, 3) != 0), W'($urandom), a);
            end
            drain();
        end

        // Random bursts of continuous supply.
        for (int i = 0; i < 6; i++) begin
            wl.delete();
            for (int j = 0; j < 4; j++) wl.push_back(W'($urandom));
            stream(i % 2, wl);
            drain();
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
